// File: rtl/wb_master_arbiter_pkg.sv
// Shared widths and arbiter state type for the two-master Wishbone arbiter.
package wb_master_arbiter_pkg;

    localparam int unsigned WB_ADR_W = 24;
    localparam int unsigned WB_DAT_W = 16;
    localparam int unsigned WB_SEL_W = 2;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_OWN0,
        ARB_OWN1,
        ARB_ABORT,
        ARB_DRAIN
    } arb_state_t;

endpackage

// File: rtl/wb_master_arbiter_if.sv
// One Wishbone port: the master modport drives a request, the slave modport answers it.
interface wb_master_arbiter_if;
    import wb_master_arbiter_pkg::*;

    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] wdat;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] rdat;
    logic                ack;
    logic                err;

    modport master (output cyc, stb, we, adr, wdat, sel, input rdat, ack, err);
    modport slave  (input cyc, stb, we, adr, wdat, sel, output rdat, ack, err);

endinterface

// File: rtl/wb_master_arbiter_watchdog.sv
// Counts consecutive unanswered strobe cycles and flags the last one before abort.
module wb_master_arbiter_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] ONE  = TO_W'(1);

    logic [TO_W-1:0] cnt;

    // Count while the access stays unanswered; any answer, idle strobe or state change restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    assign expire = (TIMEOUT != 0) && run && (cnt == LAST);

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: cyc-locked grant, bus mux and watchdog abort of hung accesses.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TO_W       = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    wb_master_arbiter_if.slave        m0,
    wb_master_arbiter_if.slave        m1,
    wb_master_arbiter_if.master       s,
    output logic [1:0]                o_grant,
    output logic                      o_timeout
);

    arb_state_t state, state_nxt;
    logic [1:0] grant, grant_nxt;
    logic       last_m1, last_m1_nxt;
    logic       set_timeout;
    logic       owning, own_cyc, own_stb;
    logic       wd_run, wd_clear, wd_expire;

    assign owning   = (state == ARB_OWN0) || (state == ARB_OWN1);
    assign own_cyc  = grant[1] ? m1.cyc : m0.cyc;
    assign own_stb  = grant[1] ? m1.stb : m0.stb;
    assign wd_run   = owning && own_stb && !s.ack && !s.err;
    assign wd_clear = (state_nxt != state);

    wb_master_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .run    (wd_run),
        .clear  (wd_clear),
        .expire (wd_expire)
    );

    // State, owner, round-robin history and sticky abort flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            last_m1   <= 1'b1;
            o_timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            last_m1 <= last_m1_nxt;
            if (set_timeout) begin
                o_timeout <= 1'b1;
            end
        end
    end

    // Grant selection, release on cyc drop, and watchdog abort sequencing.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        last_m1_nxt = last_m1;
        set_timeout = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (m0.cyc && (!m1.cyc || FIXED_PRIO || last_m1)) begin
                    state_nxt = ARB_OWN0;
                    grant_nxt = 2'b01;
                end else if (m1.cyc) begin
                    state_nxt = ARB_OWN1;
                    grant_nxt = 2'b10;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (!own_cyc) begin
                    state_nxt   = ARB_IDLE;
                    grant_nxt   = '0;
                    last_m1_nxt = grant[1];
                end else if (wd_expire) begin
                    state_nxt   = ARB_ABORT;
                    set_timeout = 1'b1;
                end
            end
            ARB_ABORT: begin
                state_nxt = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                if (!own_cyc) begin
                    state_nxt   = ARB_IDLE;
                    grant_nxt   = '0;
                    last_m1_nxt = grant[1];
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    assign o_grant = grant;

    // Forward the owner's request only while it owns a live access; everything else reads as zero.
    assign s.cyc  = owning && own_cyc;
    assign s.stb  = owning && own_stb;
    assign s.we   = owning && (grant[1] ? m1.we : m0.we);
    assign s.adr  = owning ? (grant[1] ? m1.adr  : m0.adr)  : '0;
    assign s.wdat = owning ? (grant[1] ? m1.wdat : m0.wdat) : '0;
    assign s.sel  = owning ? (grant[1] ? m1.sel  : m0.sel)  : '0;

    assign m0.ack  = owning && grant[0] && s.ack && m0.stb;
    assign m1.ack  = owning && grant[1] && s.ack && m1.stb;
    assign m0.err  = grant[0] && ((owning && s.err && m0.stb) || (state == ARB_ABORT));
    assign m1.err  = grant[1] && ((owning && s.err && m1.stb) || (state == ARB_ABORT));
    assign m0.rdat = (owning && grant[0]) ? s.rdat : '0;
    assign m1.rdat = (owning && grant[1]) ? s.rdat : '0;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: a round-robin and a fixed-priority instance share one stimulus.
module tb_wb_master_arbiter;
    import wb_master_arbiter_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mc[2], ms[2], mw[2];
    logic [23:0] ma[2];
    logic [15:0] md[2];
    logic [1:0]  msel[2];
    logic        sack, serr;
    logic [15:0] srd;

    int passed = 0;
    int total  = 0;

    wb_master_arbiter_if m0_rr(), m1_rr(), s_rr(), m0_fp(), m1_fp(), s_fp();

    assign m0_rr.cyc = mc[0]; assign m0_rr.stb = ms[0]; assign m0_rr.we = mw[0];
    assign m0_rr.adr = ma[0]; assign m0_rr.wdat = md[0]; assign m0_rr.sel = msel[0];
    assign m1_rr.cyc = mc[1]; assign m1_rr.stb = ms[1]; assign m1_rr.we = mw[1];
    assign m1_rr.adr = ma[1]; assign m1_rr.wdat = md[1]; assign m1_rr.sel = msel[1];
    assign m0_fp.cyc = mc[0]; assign m0_fp.stb = ms[0]; assign m0_fp.we = mw[0];
    assign m0_fp.adr = ma[0]; assign m0_fp.wdat = md[0]; assign m0_fp.sel = msel[0];
    assign m1_fp.cyc = mc[1]; assign m1_fp.stb = ms[1]; assign m1_fp.we = mw[1];
    assign m1_fp.adr = ma[1]; assign m1_fp.wdat = md[1]; assign m1_fp.sel = msel[1];
    assign s_rr.rdat = srd; assign s_rr.ack = sack; assign s_rr.err = serr;
    assign s_fp.rdat = srd; assign s_fp.ack = sack; assign s_fp.err = serr;

    logic [1:0]  g_act[2];
    logic        to_act[2];
    logic [44:0] bus_act[2];
    logic [17:0] ret_act[2][2];

    wb_master_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(TO), .TO_W(8)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .m0(m0_rr), .m1(m1_rr), .s(s_rr),
        .o_grant(g_act[0]), .o_timeout(to_act[0])
    );
    wb_master_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(TO), .TO_W(8)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n), .m0(m0_fp), .m1(m1_fp), .s(s_fp),
        .o_grant(g_act[1]), .o_timeout(to_act[1])
    );

    assign bus_act[0] = {s_rr.cyc, s_rr.stb, s_rr.we, s_rr.adr, s_rr.wdat, s_rr.sel};
    assign bus_act[1] = {s_fp.cyc, s_fp.stb, s_fp.we, s_fp.adr, s_fp.wdat, s_fp.sel};
    assign ret_act[0][0] = {m0_rr.ack, m0_rr.err, m0_rr.rdat};
    assign ret_act[0][1] = {m1_rr.ack, m1_rr.err, m1_rr.rdat};
    assign ret_act[1][0] = {m0_fp.ack, m0_fp.err, m0_fp.rdat};
    assign ret_act[1][1] = {m1_fp.ack, m1_fp.err, m1_fp.rdat};

    // Reference model state, one set per instance (index 1 = fixed priority).
    int owner[2];
    int last_own[2];
    int unanswered[2];
    bit aborting[2];
    bit draining[2];
    bit sticky[2];

    typedef struct {
        logic c0, s0, c1, s1, ack;
        logic [1:0] g_rr, g_fp;
        logic scyc, a0, a1;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1; last_own[d] = 1; unanswered[d] = 0;
            aborting[d] = 0; draining[d] = 0; sticky[d] = 0;
        end
    endtask

    task automatic model_step();
        int o;
        for (int d = 0; d < 2; d++) begin
            o = owner[d];
            if (o < 0) begin
                if (mc[0] && mc[1]) owner[d] = (d == 1) ? 0 : 1 - last_own[d];
                else if (mc[0]) owner[d] = 0;
                else if (mc[1]) owner[d] = 1;
                unanswered[d] = 0;
            end else if (aborting[d]) begin
                aborting[d] = 0;
                draining[d] = 1;
            end else if (draining[d]) begin
                if (!mc[o]) begin
                    last_own[d] = o; owner[d] = -1; draining[d] = 0;
                end
            end else if (!mc[o]) begin
                last_own[d] = o; owner[d] = -1; unanswered[d] = 0;
            end else if (ms[o] && !sack && !serr) begin
                unanswered[d]++;
                if (unanswered[d] == TO) begin
                    aborting[d] = 1; sticky[d] = 1; unanswered[d] = 0;
                end
            end else begin
                unanswered[d] = 0;
            end
        end
    endtask

    task automatic model_check();
        int o, oi;
        bit fwd;
        logic [1:0] eg;
        logic [44:0] eb;
        logic [17:0] er;
        for (int d = 0; d < 2; d++) begin
            o   = owner[d];
            oi  = (o < 0) ? 0 : o;
            fwd = (o >= 0) && !aborting[d] && !draining[d];
            eg  = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
            eb  = fwd ? {mc[oi], ms[oi], mw[oi], ma[oi], md[oi], msel[oi]} : '0;
            chk($sformatf("rnd_grant[%0d]", d), 64'(g_act[d]), 64'(eg));
            chk($sformatf("rnd_bus[%0d]", d), 64'(bus_act[d]), 64'(eb));
            chk($sformatf("rnd_timeout[%0d]", d), 64'(to_act[d]), 64'(sticky[d]));
            for (int k = 0; k < 2; k++) begin
                er = {fwd && (o == k) && sack && ms[k],
                      (o == k) && (aborting[d] || (fwd && serr && ms[k])),
                      (fwd && (o == k)) ? srd : 16'h0000};
                chk($sformatf("rnd_ret[%0d][m%0d]", d, k), 64'(ret_act[d][k]), 64'(er));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int ack_pct;
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0; ms[k] = 0; mw[k] = 0; ma[k] = '0; md[k] = '0; msel[k] = '0;
        end
        sack = 0; serr = 0; srd = '0;

        //           c0 s0 c1 s1 ack  g_rr   g_fp  scyc a0 a1
        tbl[0]  = '{1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 1, 2'b01, 2'b01, 1, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[5]  = '{1, 1, 1, 1, 1, 2'b10, 2'b01, 1, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0};
        tbl[7]  = '{1, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 2'b01, 2'b01, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 1, 1, 2'b10, 2'b10, 1, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};

        // Reset values
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_grant[%0d]", d), 64'(g_act[d]), 64'd0);
            chk($sformatf("reset_timeout[%0d]", d), 64'(to_act[d]), 64'd0);
            chk($sformatf("reset_bus[%0d]", d), 64'(bus_act[d]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1;
        tick();

        // Arbitration table: tie-break, alternation, fixed priority, idle gap
        for (int i = 0; i < 15; i++) begin
            mc[0] = tbl[i].c0; ms[0] = tbl[i].s0;
            mc[1] = tbl[i].c1; ms[1] = tbl[i].s1;
            sack  = tbl[i].ack;
            #1;
            chk($sformatf("tbl%0d_grant_rr", i), 64'(g_act[0]), 64'(tbl[i].g_rr));
            chk($sformatf("tbl%0d_grant_fp", i), 64'(g_act[1]), 64'(tbl[i].g_fp));
            chk($sformatf("tbl%0d_scyc_rr", i), 64'(bus_act[0][44]), 64'(tbl[i].scyc));
            chk($sformatf("tbl%0d_m0ack_rr", i), 64'(ret_act[0][0][17]), 64'(tbl[i].a0));
            chk($sformatf("tbl%0d_m1ack_rr", i), 64'(ret_act[0][1][17]), 64'(tbl[i].a1));
            tick();
        end

        // m0 write, slave acks on the third wait cycle
        mc[0] = 1; ms[0] = 1; mw[0] = 1; ma[0] = 24'h000123; md[0] = 16'hBEEF; msel[0] = 2'b11;
        #1;
        chk("wr_idle_scyc", 64'(bus_act[0][44]), 64'd0);
        tick();
        chk("wr_bus", 64'(bus_act[0]), 64'({1'b1, 1'b1, 1'b1, 24'h000123, 16'hBEEF, 2'b11}));
        chk("wr_m0ack_wait", 64'(ret_act[0][0][17]), 64'd0);
        tick();
        tick();
        sack = 1;
        #1;
        chk("wr_m0ack", 64'(ret_act[0][0][17]), 64'd1);
        chk("wr_m1ack", 64'(ret_act[0][1][17]), 64'd0);
        chk("wr_m0ack_fp", 64'(ret_act[1][0][17]), 64'd1);
        tick();
        sack = 0; ms[0] = 0;
        #1;
        chk("wr_m0ack_after", 64'(ret_act[0][0][17]), 64'd0);
        mc[0] = 0; mw[0] = 0;
        tick();
        tick();

        // Ack lands on the cycle the watchdog would expire
        mc[0] = 1; ms[0] = 1; ma[0] = 24'h00ABCD;
        tick();
        repeat (TO - 1) tick();
        sack = 1; srd = 16'hC3C3;
        #1;
        chk("edge_m0_ret", 64'(ret_act[0][0]), 64'({1'b1, 1'b0, 16'hC3C3}));
        chk("edge_m1_ret", 64'(ret_act[0][1]), 64'd0);
        tick();
        sack = 0; ms[0] = 0;
        #1;
        chk("edge_m0_err_after", 64'(ret_act[0][0][16]), 64'd0);
        chk("edge_grant", 64'(g_act[0]), 64'd1);
        chk("edge_scyc", 64'(bus_act[0][44]), 64'd1);
        mc[0] = 0;
        tick();
        tick();
        chk("edge_timeout_rr", 64'(to_act[0]), 64'd0);
        chk("edge_timeout_fp", 64'(to_act[1]), 64'd0);

        // m1 read to a hung slave, m0 pending behind it
        mc[1] = 1; ms[1] = 1; mw[1] = 0; ma[1] = 24'hFFFFFE;
        tick();
        mc[0] = 1; ms[0] = 1;
        #1;
        chk("hang_grant", 64'(g_act[0]), 64'd2);
        chk("hang_adr", 64'(bus_act[0][41:18]), 64'h00FFFFFE);
        repeat (TO - 1) tick();
        chk("hang_scyc_last", 64'(bus_act[0][44]), 64'd1);
        tick();
        chk("abort_scyc_stb", 64'(bus_act[0][44:43]), 64'd0);
        chk("abort_m1_ackerr", 64'(ret_act[0][1][17:16]), 64'd1);
        chk("abort_m0_ackerr", 64'(ret_act[0][0][17:16]), 64'd0);
        chk("abort_timeout_rr", 64'(to_act[0]), 64'd1);
        chk("abort_timeout_fp", 64'(to_act[1]), 64'd1);
        chk("abort_grant", 64'(g_act[0]), 64'd2);
        tick();
        sack = 1;
        #1;
        chk("drain_m1_ackerr", 64'(ret_act[0][1][17:16]), 64'd0);
        chk("drain_scyc", 64'(bus_act[0][44]), 64'd0);
        chk("drain_grant", 64'(g_act[0]), 64'd2);
        tick();
        chk("drain_hold_grant", 64'(g_act[0]), 64'd2);
        sack = 0; mc[1] = 0; ms[1] = 0;
        tick();
        chk("drain_release", 64'(g_act[0]), 64'd0);
        tick();
        chk("pending_m0_rr", 64'(g_act[0]), 64'd1);
        chk("pending_m0_fp", 64'(g_act[1]), 64'd1);
        mc[0] = 0; ms[0] = 0;
        tick();
        tick();

        // Asynchronous reset in the middle of an m1 access
        mc[1] = 1; ms[1] = 1; mw[1] = 1; sack = 1;
        tick();
        chk("rst_pre_m1ack", 64'(ret_act[0][1][17]), 64'd1);
        chk("rst_pre_grant", 64'(g_act[0]), 64'd2);
        #2;
        rst_n = 0; mc[0] = 1;
        #1;
        chk("rst_grant", 64'(g_act[0]), 64'd0);
        chk("rst_bus", 64'(bus_act[0]), 64'd0);
        chk("rst_m1_ret", 64'(ret_act[0][1]), 64'd0);
        chk("rst_timeout", 64'(to_act[0]), 64'd0);
        @(negedge clk);
        rst_n = 1; sack = 0;
        tick();
        chk("rst_first_tie_rr", 64'(g_act[0]), 64'd1);
        chk("rst_first_tie_fp", 64'(g_act[1]), 64'd1);
        mc[0] = 0; mc[1] = 0; ms[1] = 0; mw[1] = 0;
        tick();
        tick();

        // Randomised traffic against the reference model
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0; ms[k] = 0; mw[k] = 0; ma[k] = '0; md[k] = '0; msel[k] = '0;
        end
        sack = 0; serr = 0; srd = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        ack_pct = 30;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) begin
                case ($urandom_range(2))
                    0: ack_pct = 0;
                    1: ack_pct = 25;
                    default: ack_pct = 60;
                endcase
            end
            for (int k = 0; k < 2; k++) begin
                if (mc[k]) begin
                    if ($urandom_range(99) < 12) mc[k] = 0;
                end else if ($urandom_range(99) < 25) begin
                    mc[k] = 1;
                end
                ms[k]   = mc[k] && ($urandom_range(99) < (ms[k] ? 92 : 60));
                mw[k]   = 1'($urandom);
                ma[k]   = 24'($urandom);
                md[k]   = 16'($urandom);
                msel[k] = 2'($urandom);
            end
            sack = ($urandom_range(99) < ack_pct);
            serr = !sack && ($urandom_range(99) < 4);
            srd  = 16'($urandom);
            #1;
            model_check();
            @(posedge clk);
            model_step();
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
